dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Memory-side responder for the pipeline's MEM-stage load/store requests; owns a word-wide data array.
// - Performs byte/half/word lane selection, load sign/zero extension and store byte merging.
// - Inserts a configurable wait latency and drives stall back to the pipeline until each response is delivered.
// - Sits between the EX/MEM register outputs and the MEM/WB register inputs.
// PARAMETERS
// - DEPTH        1024  data array size in 32-bit words; word index = addr[31:2]
// - WAIT_CYCLES  2     extra cycles between accept and response; 0 is legal
// PORTS
// - clk        in   1   single clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - req_valid  in   1   request present; initiator holds all req_* stable while stall=1
// - req_rd     in   1   load request
// - req_wt     in   1   store request; req_rd=req_wt=1 is illegal, treated as load
// - req_addr   in   32  byte address
// - req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - req_load   in   3   0=LW 1=LB 2=LBU 3=LH 4=LHU; 5-7 -> err
// - req_store  in   2   0=SW 1=SB 2=SH; 3 -> err
// - req_ready  out  1   high only in IDLE
// - stall      out  1   (req_valid & IDLE) | WAIT; pipeline freezes IF..EX/MEM while high
// - rsp_valid  out  1   one-cycle pulse, response data valid
// - rsp_rdata  out  32  extended load data; 0 for stores and errors
// - rsp_err    out  1   misaligned access or word index >= DEPTH, qualified by rsp_valid
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=1, stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   Array contents not reset.
// - FSM IDLE->(WAIT)->RESP->IDLE.
//   - IDLE: on req_valid&(req_rd|req_wt), latch addr/wdata/op.
//     WAIT_CYCLES>0 -> WAIT with counter=WAIT_CYCLES-1; else -> RESP.
//   - WAIT: counter decrements each cycle; at 0 -> RESP.
//   - RESP: rsp_valid=1 for exactly this cycle -> IDLE.
// - Commit edge (the edge entering RESP):
//   - Stores write the array on this edge.
//   - Loads register rsp_rdata on this edge; rsp_rdata holds until the next commit.
// - Latency: rsp_valid high exactly WAIT_CYCLES+1 cycles after the accept edge.
// - Throughput: one request per WAIT_CYCLES+2 cycles.
// - req_valid with neither rd nor wt is ignored: no accept, stall=0.
// - Byte lanes are little-endian, lane = addr[1:0].
//   - SB writes lane addr[1:0] only.
//   - SH writes lanes {addr[1],1} and {addr[1],0}.
//   - SW writes all four lanes.
// - Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
// - Errors: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; index out of range; illegal code.
//   - Same latency as a normal access; no array write; rsp_rdata=0, rsp_err=1.
// - Read-after-write: a load accepted after a store's RESP sees the stored data.
// - rst mid-operation: returns to reset values immediately.
//   - A store still in WAIT is dropped and the array is unchanged.
//   - A store that has passed its commit edge stays written.
// STRUCTURE
// - Shared header dmem_defs.vh: load/store code defines, FSM state encodings (IDLE/WAIT/RESP).
// - One sub-module dmem_lane_unit (combinational): store merge (old word, wdata, addr[1:0], store code)
//   -> new word; load extract (word, addr[1:0], load code) -> extended data; misalignment flag.
// - Top holds the FSM, wait counter, request latches and the array (reg [31:0] mem[0:DEPTH-1]).
// TESTING
// - WAIT_CYCLES=2: SW 0x10 data 0xDEADBEEF -> rsp_valid 3 cycles after accept, err=0; then LW 0x10 -> 0xDEADBEEF.
// - SB 0x13 data 0x000000A5:
//   - LW 0x10 -> 0xA5ADBEEF
//   - LB 0x13 -> 0xFFFFFFA5
//   - LBU 0x13 -> 0x000000A5
// - SH 0x12 data 0x00001234:
//   - LW 0x10 -> 0x1234BEEF
//   - LH 0x12 -> 0x00001234
//   - LH 0x10 -> 0xFFFFBEEF
//   - LHU 0x10 -> 0x0000BEEF
// - LW 0x11 -> rsp_err=1, rdata=0; SW 0x12 data 0xFFFFFFFF -> err=1; LW 0x10 still 0x1234BEEF.
// - SW 0x20 data 0x1, then SW 0x20 data 0x2 with rst pulsed during its WAIT:
//   - outputs return to reset values that cycle
//   - LW 0x20 -> 0x00000001
// - req_valid held high continuously: accepts spaced 4 cycles apart (WAIT=2); stall low only in RESP.
//   WAIT_CYCLES=0 build: rsp_valid 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared codes, FSM encodings and helpers for the data-memory responder
package dmem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [1:0] SD_SW = 2'd0;
    localparam logic [1:0] SD_SB = 2'd1;
    localparam logic [1:0] SD_SH = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_load;
        logic [2:0]  load_op;
        logic [1:0]  store_op;
    } req_t;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bus between pipeline and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_rd;
    logic        req_wt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_load;
    logic [1:0]  req_store;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_rd, req_wt, req_addr, req_wdata, req_load, req_store,
        input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_rd, req_wt, req_addr, req_wdata, req_load, req_store,
        output req_ready, stall, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_lane_unit.sv
// rtl/dmem_responder_lane_unit.sv - byte-lane store merge, load extraction/extension and alignment check
module dmem_responder_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic        is_load,
    input  logic [2:0]  load_op,
    input  logic [1:0]  store_op,
    output logic [31:0] new_word,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{offset, 3'b000} +: 8];
    assign half_v = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        new_word  = word;
        load_data = '0;
        bad       = 1'b0;
        if (is_load) begin
            case (load_op)
                LD_LW:  begin load_data = word;                bad = (offset != 2'b00); end
                LD_LB:  load_data = ext8(byte_v, 1'b1);
                LD_LBU: load_data = ext8(byte_v, 1'b0);
                LD_LH:  begin load_data = ext16(half_v, 1'b1); bad = offset[0]; end
                LD_LHU: begin load_data = ext16(half_v, 1'b0); bad = offset[0]; end
                default: bad = 1'b1;
            endcase
        end else begin
            case (store_op)
                SD_SW: begin new_word = wdata; bad = (offset != 2'b00); end
                SD_SB: new_word[{offset, 3'b000} +: 8] = wdata[7:0];
                SD_SH: begin
                    if (offset[1]) new_word[31:16] = wdata[15:0];
                    else           new_word[15:0]  = wdata[15:0];
                    bad = offset[0];
                end
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder with wait latency and pipeline stall
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
)(
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    req_t          lat;
    req_t          live;
    req_t          cur;
    logic [31:0]   mem [0:DEPTH-1];
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          commit;
    logic          oob;
    logic          lane_bad;
    logic          access_err;
    logic          wr_en;
    logic [IW-1:0] idx;
    logic [31:0]   old_word;
    logic [31:0]   new_word;
    logic [31:0]   load_data;

    assign accept = (state == ST_IDLE) && bus.req_valid && (bus.req_rd || bus.req_wt);

    assign live = '{addr:     bus.req_addr,
                    wdata:    bus.req_wdata,
                    is_load:  bus.req_rd,
                    load_op:  bus.req_load,
                    store_op: bus.req_store};

    // With no wait cycles the accept edge is also the commit edge, so the live request is used.
    assign cur    = (state == ST_IDLE) ? live : lat;
    assign commit = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == '0));

    assign idx        = cur.addr[IW+1:2];
    assign oob        = (cur.addr[31:2] >= 30'(DEPTH));
    assign old_word   = mem[idx];
    assign access_err = lane_bad || oob;
    assign wr_en      = commit && !cur.is_load && !access_err && !rst;

    dmem_responder_lane_unit lane (
        .word      (old_word),
        .wdata     (cur.wdata),
        .offset    (cur.addr[1:0]),
        .is_load   (cur.is_load),
        .load_op   (cur.load_op),
        .store_op  (cur.store_op),
        .new_word  (new_word),
        .load_data (load_data),
        .bad       (lane_bad)
    );

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= new_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat <= live;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (commit) begin
                rdata_q <= (cur.is_load && !access_err) ? load_data : '0;
                err_q   <= access_err;
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.stall     = accept || (state == ST_WAIT);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 builds)
module tb_dmem_responder;

    localparam int LAT_A = 3;
    localparam int LAT_Z = 1;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t  sb_q[$];
    string nm_q[$];
    exp_t  sb_z[$];

    dmem_responder_if if_a();
    dmem_responder_if if_z();

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(if_a));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin
        exp_t  x;
        string n;
        if (if_a.rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rdata=%h err=%b with empty scoreboard", if_a.rsp_rdata, if_a.rsp_err);
            end else begin
                x = sb_q.pop_front();
                n = nm_q.pop_front();
                if (if_a.rsp_rdata !== x.d || if_a.rsp_err !== x.e) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b", n, if_a.rsp_rdata, if_a.rsp_err, x.d, x.e);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t y;
        if (if_z.rsp_valid) begin
            checks++;
            if (sb_z.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp_w0: rdata=%h err=%b", if_z.rsp_rdata, if_z.rsp_err);
            end else begin
                y = sb_z.pop_front();
                if (if_z.rsp_rdata !== y.d || if_z.rsp_err !== y.e) begin
                    errors++;
                    $display("FAIL w0_rsp: got rdata=%h err=%b, want rdata=%h err=%b", if_z.rsp_rdata, if_z.rsp_err, y.d, y.e);
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wt, input logic [2:0] lc, input logic [1:0] sc,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input string name);
        int n;
        @(negedge clk);
        if_a.req_valid = 1'b1; if_a.req_rd = rd; if_a.req_wt = wt;
        if_a.req_load = lc; if_a.req_store = sc; if_a.req_addr = a; if_a.req_wdata = wd;
        sb_q.push_back('{d: exp_d, e: exp_e});
        nm_q.push_back(name);
        #1;
        checks++;
        if (if_a.req_ready !== 1'b1 || if_a.stall !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: req_ready=%b stall=%b, want 1 1", name, if_a.req_ready, if_a.stall);
        end
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!if_a.rsp_valid && if_a.stall !== 1'b1) begin
                checks++; errors++;
                $display("FAIL %s_wait_stall: stall=%b want 1", name, if_a.stall);
            end
        end while (!if_a.rsp_valid && n < 20);
        checks++;
        if (n != LAT_A) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, n, LAT_A);
        end
        checks++;
        if (if_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp_stall: stall=%b want 0", name, if_a.stall);
        end
        if_a.req_valid = 1'b0; if_a.req_rd = 1'b0; if_a.req_wt = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (if_a.req_ready !== 1'b1 || if_a.stall !== 1'b0 || if_a.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b stall=%b rsp_valid=%b, want 1 0 0", if_a.req_ready, if_a.stall, if_a.rsp_valid);
        end
        checks++;
        if (if_a.rsp_rdata !== 32'h0 || if_a.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h err=%b, want 0 0", if_a.rsp_rdata, if_a.rsp_err);
        end
        checks++;
        if (if_z.req_ready !== 1'b1 || if_z.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_w0: ready=%b rsp_valid=%b, want 1 0", if_z.req_ready, if_z.rsp_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_word_byte_half;
        do_req(1'b0, 1'b1, 3'd0, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10_a");
        do_req(1'b0, 1'b1, 3'd0, 2'd1, 32'h13, 32'h000000A5, 32'h0, 1'b0, "sb_13");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, "lw_10_b");
        do_req(1'b1, 1'b0, 3'd1, 2'd0, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, "lb_13");
        do_req(1'b1, 1'b0, 3'd2, 2'd0, 32'h13, 32'h0, 32'h000000A5, 1'b0, "lbu_13");
        do_req(1'b0, 1'b1, 3'd0, 2'd2, 32'h12, 32'h00001234, 32'h0, 1'b0, "sh_12");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_c");
        do_req(1'b1, 1'b0, 3'd3, 2'd0, 32'h12, 32'h0, 32'h00001234, 1'b0, "lh_12");
        do_req(1'b1, 1'b0, 3'd3, 2'd0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_10");
        do_req(1'b1, 1'b0, 3'd4, 2'd0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
        do_req(1'b1, 1'b0, 3'd1, 2'd0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, "lb_11");
        do_req(1'b1, 1'b1, 3'd2, 2'd1, 32'h12, 32'hFFFFFFFF, 32'h00000034, 1'b0, "rdwt_as_lbu_12");
    endtask

    task automatic test_errors;
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h11, 32'h0, 32'h0, 1'b1, "lw_misaligned");
        do_req(1'b0, 1'b1, 3'd0, 2'd0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_misaligned");
        do_req(1'b1, 1'b0, 3'd3, 2'd0, 32'h11, 32'h0, 32'h0, 1'b1, "lh_misaligned");
        do_req(1'b0, 1'b1, 3'd0, 2'd2, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1, "sh_misaligned");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h1000, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
        do_req(1'b0, 1'b1, 3'd0, 2'd1, 32'h1003, 32'h77, 32'h0, 1'b1, "sb_out_of_range");
        do_req(1'b1, 1'b0, 3'd5, 2'd0, 32'h10, 32'h0, 32'h0, 1'b1, "load_code_5");
        do_req(1'b0, 1'b1, 3'd0, 2'd3, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "store_code_3");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'hFFC, 32'h0, 32'h0, 1'b0, "lw_last_word_ok");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_after_errors");
    endtask

    task automatic test_ignored_request;
        @(negedge clk);
        if_a.req_valid = 1'b1; if_a.req_rd = 1'b0; if_a.req_wt = 1'b0;
        #1;
        checks++;
        if (if_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL ignored_stall: stall=%b want 0", if_a.stall);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_a.req_ready !== 1'b1 || if_a.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignored_idle: ready=%b rsp_valid=%b, want 1 0", if_a.req_ready, if_a.rsp_valid);
            end
        end
        if_a.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_store;
        do_req(1'b0, 1'b1, 3'd0, 2'd0, 32'h20, 32'h1, 32'h0, 1'b0, "sw_20_first");
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_before_rst");
        @(negedge clk);
        if_a.req_valid = 1'b1; if_a.req_rd = 1'b0; if_a.req_wt = 1'b1;
        if_a.req_store = 2'd0; if_a.req_addr = 32'h20; if_a.req_wdata = 32'h2;
        @(negedge clk);
        checks++;
        if (if_a.req_ready !== 1'b0 || if_a.stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_wait: ready=%b stall=%b, want 0 1", if_a.req_ready, if_a.stall);
        end
        #1;
        rst = 1'b1;
        if_a.req_valid = 1'b0; if_a.req_wt = 1'b0;
        #1;
        checks++;
        if (if_a.req_ready !== 1'b1 || if_a.stall !== 1'b0 || if_a.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: ready=%b stall=%b rsp_valid=%b, want 1 0 0", if_a.req_ready, if_a.stall, if_a.rsp_valid);
        end
        checks++;
        if (if_a.rsp_rdata !== 32'h0 || if_a.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_data: rdata=%h err=%b, want 0 0", if_a.rsp_rdata, if_a.rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b1, 1'b0, 3'd0, 2'd0, 32'h20, 32'h0, 32'h00000001, 1'b0, "lw_20_after_rst");
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_t [3];
        logic [2:0]  l_t [3];
        logic [31:0] d_t [3];
        int acc[$];
        int k;
        a_t = '{32'h10, 32'h11, 32'h12};
        l_t = '{3'd0, 3'd1, 3'd4};
        d_t = '{32'h1234BEEF, 32'hFFFFFFBE, 32'h00001234};
        k = 0;
        @(negedge clk);
        if_a.req_valid = 1'b1; if_a.req_rd = 1'b1; if_a.req_wt = 1'b0;
        if_a.req_addr = a_t[0]; if_a.req_load = l_t[0];
        #1;
        for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
            checks++;
            if (if_a.stall !== !if_a.rsp_valid) begin
                errors++;
                $display("FAIL b2b_stall: cycle %0d stall=%b rsp_valid=%b", cyc, if_a.stall, if_a.rsp_valid);
            end
            if (if_a.req_ready) begin
                acc.push_back(cyc);
                sb_q.push_back('{d: d_t[k], e: 1'b0});
                nm_q.push_back("b2b_load");
            end
            if (if_a.rsp_valid) begin
                k++;
                if (k < 3) begin
                    if_a.req_addr = a_t[k]; if_a.req_load = l_t[k];
                end else begin
                    if_a.req_valid = 1'b0; if_a.req_rd = 1'b0;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (k != 3 || acc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: responses=%0d accepts=%0d, want 3 3", k, acc.size());
            if_a.req_valid = 1'b0;
        end else begin
            checks++;
            if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d %0d, want 4 4", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp_d;
        int n;
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            if_z.req_valid = 1'b1;
            if_z.req_rd    = (op == 1);
            if_z.req_wt    = (op == 0);
            if_z.req_load  = 3'd0;
            if_z.req_store = 2'd0;
            if_z.req_addr  = 32'h40;
            if_z.req_wdata = 32'hCAFEF00D;
            exp_d = (op == 1) ? 32'hCAFEF00D : 32'h0;
            sb_z.push_back('{d: exp_d, e: 1'b0});
            @(posedge clk);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!if_z.rsp_valid && n < 10);
            checks++;
            if (n != LAT_Z) begin
                errors++;
                $display("FAIL w0_latency: op %0d got %0d cycles, want %0d", op, n, LAT_Z);
            end
            if_z.req_valid = 1'b0; if_z.req_rd = 1'b0; if_z.req_wt = 1'b0;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        if_a.req_valid = 1'b0; if_a.req_rd = 1'b0; if_a.req_wt = 1'b0;
        if_a.req_addr = '0; if_a.req_wdata = '0; if_a.req_load = '0; if_a.req_store = '0;
        if_z.req_valid = 1'b0; if_z.req_rd = 1'b0; if_z.req_wt = 1'b0;
        if_z.req_addr = '0; if_z.req_wdata = '0; if_z.req_load = '0; if_z.req_store = '0;

        test_reset();
        test_word_byte_half();
        test_errors();
        test_ignored_request();
        test_reset_mid_store();
        test_back_to_back();
        test_zero_wait();

        for (int i = 0; i < 10 && (sb_q.size() != 0 || sb_z.size() != 0); i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || sb_z.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d/%0d, want 0/0", sb_q.size(), sb_z.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
